// File: rtl/can_pkg.sv
// Shared CAN definitions used by the receive core, the transmitter and the CRC
// block: FSM state encoding, field widths, CRC polynomial and bus timing lengths.
package can_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ARB,
      ST_CTRL,
      ST_DATA,
      ST_CRC,
      ST_CRC_DEL,
      ST_ACK_SLOT,
      ST_ACK_DEL,
      ST_EOF,
      ST_ERR
   } can_state_t;

   localparam int ID_W  = 11;
   localparam int DLC_W = 4;
   localparam int CRC_W = 15;

   localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

   localparam int STUFF_LIMIT = 5;
   localparam int EOF_LEN     = 7;
   localparam int IDLE_LEN    = 11;

   // Number of payload bits carried by a frame: none for remote frames,
   // otherwise DLC bytes capped at eight.
   function automatic logic [6:0] data_bits(input logic rtr, input logic [DLC_W-1:0] dlc);
      if (rtr)
         return 7'd0;
      else if (dlc > 4'd8)
         return 7'd64;
      else
         return {dlc, 3'b000};
   endfunction

endpackage

// File: rtl/can_rx_core_if.sv
// Bus-side and delivery-side signals of the CAN receive core.
//   baud_clk  : one-clk sample strobe per bit time
//   CAN_RX    : raw bus level (0 = dominant)
//   ack_drive : request to drive the ACK slot dominant
//   rx_*      : last delivered frame and its one-clk valid pulse
//   stuff_err, crc_err, form_err : one-clk error pulses
//   busy      : receiver is inside a frame or error recovery
// master = bus/host side, slave = receive core.
interface can_rx_core_if;
   import can_pkg::*;

   logic             baud_clk;
   logic             CAN_RX;
   logic             ack_drive;
   logic [ID_W-1:0]  rx_id;
   logic             rx_rtr;
   logic [DLC_W-1:0] rx_dlc;
   logic [63:0]      rx_data;
   logic             rx_valid;
   logic             stuff_err;
   logic             crc_err;
   logic             form_err;
   logic             busy;

   modport master (
      output baud_clk, CAN_RX,
      input  ack_drive, rx_id, rx_rtr, rx_dlc, rx_data, rx_valid,
      input  stuff_err, crc_err, form_err, busy
   );

   modport slave (
      input  baud_clk, CAN_RX,
      output ack_drive, rx_id, rx_rtr, rx_dlc, rx_data, rx_valid,
      output stuff_err, crc_err, form_err, busy
   );

endinterface

// File: rtl/can_crc15.sv
// CAN CRC-15 (polynomial 0x4599, initial value 0), one bit per enabled clk.
//   clk, RESET : clock and asynchronous active-low reset
//   clear      : synchronous return to the initial value (wins over enable)
//   enable     : fold bit_in into the running CRC
//   crc        : current CRC register
module can_crc15
   import can_pkg::*;
(
   input  logic             clk,
   input  logic             RESET,
   input  logic             clear,
   input  logic             enable,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc
);

   logic fb;

   assign fb = bit_in ^ crc[CRC_W-1];

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET)
         crc <= '0;
      else if (clear)
         crc <= '0;
      else if (enable)
         crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
   end

endmodule

// File: rtl/can_rx_core.sv
// CAN 2.0A (standard identifier) receive core: bus synchronizer, de-stuffing,
// frame field decode, CRC-15 check, ACK request, acceptance filter and
// error detection with 11-bit recessive recovery.
//   clk   : system clock
//   RESET : asynchronous active-low reset
//   bus   : can_rx_core_if.slave (sample strobe, bus level, outputs)
module can_rx_core
   import can_pkg::*;
#(
   parameter logic [ID_W-1:0] ADDRESS    = 11'h25,
   parameter bit              ACCEPT_ALL = 1'b0
) (
   input logic          clk,
   input logic          RESET,
   can_rx_core_if.slave bus
);

   localparam logic [2:0] STUFF_CNT = 3'(STUFF_LIMIT);
   localparam logic [6:0] ARB_LAST  = 7'(ID_W);          // ID bits 0..10, RTR at 11
   localparam logic [6:0] CTRL_LAST = 7'(2 + DLC_W - 1); // IDE, r0, DLC[3:0]
   localparam logic [6:0] CRC_LAST  = 7'(CRC_W - 1);
   localparam logic [6:0] EOF_LAST  = 7'(EOF_LEN - 1);
   localparam logic [6:0] IDLE_LAST = 7'(IDLE_LEN - 1);

   can_state_t       state;
   logic             sync_p0, sync_p1;
   logic [6:0]       bit_cnt;
   logic             last_bit;
   logic [2:0]       same_cnt;
   logic [ID_W-1:0]  id_sr;
   logic             rtr_r;
   logic [DLC_W-1:0] dlc_sr;
   logic [6:0]       nbits;
   logic [63:0]      data_sr;
   logic [CRC_W-1:0] crc_sr;
   logic [CRC_W-1:0] crc_calc;

   logic             ack_drive_r, rx_valid_r, stuff_err_r, crc_err_r, form_err_r;
   logic [ID_W-1:0]  rx_id_r;
   logic             rx_rtr_r;
   logic [DLC_W-1:0] rx_dlc_r;
   logic [63:0]      rx_data_r;

   logic             samp, rx_bit, stuff_zone, stuff_bit, crc_en;
   logic [5:0]       data_idx;
   logic [6:0]       nbits_next;

   assign samp       = bus.baud_clk;
   assign rx_bit     = sync_p1;
   assign stuff_zone = (state == ST_ARB) || (state == ST_CTRL) ||
                       (state == ST_DATA) || (state == ST_CRC);
   // After five equal bits the next one is a stuff bit, not frame content.
   assign stuff_bit  = stuff_zone && (same_cnt == STUFF_CNT);
   // SOF is dominant and the CRC starts at 0, so folding it in is a no-op;
   // only ARB/CTRL/DATA content bits need to reach the CRC.
   assign crc_en     = samp && !stuff_bit &&
                       ((state == ST_ARB) || (state == ST_CTRL) || (state == ST_DATA));
   // First payload bit lands in bit 63 (63 - n == ~n on six bits).
   assign data_idx   = ~bit_cnt[5:0];
   assign nbits_next = data_bits(rtr_r, {dlc_sr[DLC_W-2:0], rx_bit});

   can_crc15 u_crc (
      .clk    (clk),
      .RESET  (RESET),
      .clear  (state == ST_IDLE),
      .enable (crc_en),
      .bit_in (rx_bit),
      .crc    (crc_calc)
   );

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state       <= ST_IDLE;
         sync_p0     <= 1'b0;
         sync_p1     <= 1'b0;
         bit_cnt     <= '0;
         last_bit    <= 1'b0;
         same_cnt    <= '0;
         id_sr       <= '0;
         rtr_r       <= 1'b0;
         dlc_sr      <= '0;
         nbits       <= '0;
         data_sr     <= '0;
         crc_sr      <= '0;
         ack_drive_r <= 1'b0;
         rx_valid_r  <= 1'b0;
         stuff_err_r <= 1'b0;
         crc_err_r   <= 1'b0;
         form_err_r  <= 1'b0;
         rx_id_r     <= '0;
         rx_rtr_r    <= 1'b0;
         rx_dlc_r    <= '0;
         rx_data_r   <= '0;
      end else begin
         // Synchronizer stage boundary: p0 -> p1
         sync_p0     <= bus.CAN_RX;
         sync_p1     <= sync_p0;
         rx_valid_r  <= 1'b0;
         stuff_err_r <= 1'b0;
         crc_err_r   <= 1'b0;
         form_err_r  <= 1'b0;

         if (samp) begin
            // Run-length tracking also covers stuff bits: a stuff bit starts a new run.
            if (stuff_zone) begin
               if (rx_bit == last_bit) begin
                  same_cnt <= same_cnt + 3'd1;
               end else begin
                  same_cnt <= 3'd1;
                  last_bit <= rx_bit;
               end
            end

            if (stuff_bit) begin
               if (rx_bit == last_bit) begin
                  stuff_err_r <= 1'b1;
                  state       <= ST_ERR;
                  bit_cnt     <= '0;
               end
            end else begin
               case (state)
                  ST_IDLE: begin
                     if (!rx_bit) begin
                        state    <= ST_ARB;
                        bit_cnt  <= '0;
                        last_bit <= 1'b0;
                        same_cnt <= 3'd1;
                        data_sr  <= '0;
                     end
                  end
                  ST_ARB: begin
                     if (bit_cnt < ARB_LAST)
                        id_sr <= {id_sr[ID_W-2:0], rx_bit};
                     else
                        rtr_r <= rx_bit;
                     if (bit_cnt == ARB_LAST) begin
                        state   <= ST_CTRL;
                        bit_cnt <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + 7'd1;
                     end
                  end
                  ST_CTRL: begin
                     if (bit_cnt == 7'd0 && rx_bit) begin
                        form_err_r <= 1'b1;
                        state      <= ST_ERR;
                        bit_cnt    <= '0;
                     end else begin
                        if (bit_cnt >= 7'd2)
                           dlc_sr <= {dlc_sr[DLC_W-2:0], rx_bit};
                        if (bit_cnt == CTRL_LAST) begin
                           nbits   <= nbits_next;
                           state   <= (nbits_next == 7'd0) ? ST_CRC : ST_DATA;
                           bit_cnt <= '0;
                        end else begin
                           bit_cnt <= bit_cnt + 7'd1;
                        end
                     end
                  end
                  ST_DATA: begin
                     data_sr[data_idx] <= rx_bit;
                     if (bit_cnt == nbits - 7'd1) begin
                        state   <= ST_CRC;
                        bit_cnt <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + 7'd1;
                     end
                  end
                  ST_CRC: begin
                     crc_sr <= {crc_sr[CRC_W-2:0], rx_bit};
                     if (bit_cnt == CRC_LAST) begin
                        state   <= ST_CRC_DEL;
                        bit_cnt <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + 7'd1;
                     end
                  end
                  ST_CRC_DEL: begin
                     // A bad delimiter is reported instead of the CRC result.
                     if (!rx_bit) begin
                        form_err_r <= 1'b1;
                        state      <= ST_ERR;
                     end else if (crc_sr != crc_calc) begin
                        crc_err_r <= 1'b1;
                        state     <= ST_ERR;
                     end else begin
                        ack_drive_r <= 1'b1;
                        state       <= ST_ACK_SLOT;
                     end
                     bit_cnt <= '0;
                  end
                  ST_ACK_SLOT: begin
                     ack_drive_r <= 1'b0;
                     state       <= ST_ACK_DEL;
                  end
                  ST_ACK_DEL: begin
                     if (!rx_bit) begin
                        form_err_r <= 1'b1;
                        state      <= ST_ERR;
                     end else begin
                        state <= ST_EOF;
                     end
                     bit_cnt <= '0;
                  end
                  ST_EOF: begin
                     if (!rx_bit) begin
                        form_err_r <= 1'b1;
                        state      <= ST_ERR;
                        bit_cnt    <= '0;
                     end else if (bit_cnt == EOF_LAST) begin
                        state <= ST_IDLE;
                        if (ACCEPT_ALL || id_sr == ADDRESS) begin
                           rx_id_r    <= id_sr;
                           rx_rtr_r   <= rtr_r;
                           rx_dlc_r   <= dlc_sr;
                           rx_data_r  <= data_sr;
                           rx_valid_r <= 1'b1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 7'd1;
                     end
                  end
                  ST_ERR: begin
                     if (!rx_bit)
                        bit_cnt <= '0;
                     else if (bit_cnt == IDLE_LAST)
                        state <= ST_IDLE;
                     else
                        bit_cnt <= bit_cnt + 7'd1;
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign bus.ack_drive = ack_drive_r;
   assign bus.rx_id     = rx_id_r;
   assign bus.rx_rtr    = rx_rtr_r;
   assign bus.rx_dlc    = rx_dlc_r;
   assign bus.rx_data   = rx_data_r;
   assign bus.rx_valid  = rx_valid_r;
   assign bus.stuff_err = stuff_err_r;
   assign bus.crc_err   = crc_err_r;
   assign bus.form_err  = form_err_r;
   assign bus.busy      = (state != ST_IDLE);

endmodule

// File: doc/can_rx_core.md
CAN_RX_CORE -- requirements
Module: can_rx_core

Interface
REQ-001 Parameter: ADDRESS, 11'h25, node identifier used by the acceptance filter.
REQ-002 Parameter: ACCEPT_ALL, 0, when 1 the filter is bypassed and every good frame is delivered.
REQ-003 Port: clk  in  1  system clock; all logic is on its rising edge.
REQ-004 Port: RESET  in  1  asynchronous, active-low reset.
REQ-005 Port: baud_clk  in  1  one-clk-wide sample strobe, one per CAN bit time, at the sample point.
REQ-006 Port: CAN_RX  in  1  bus level; 0 is dominant.
REQ-007 Port: ack_drive  out  1  1 means drive the bus dominant for the ACK slot; ORed into the TX path outside this block.
REQ-008 Port: rx_id  out  11  identifier of the last delivered frame.
REQ-009 Port: rx_rtr  out  1  RTR bit of the last delivered frame.
REQ-010 Port: rx_dlc  out  4  DLC of the last delivered frame, as received.
REQ-011 Port: rx_data  out  64  payload; the first byte is in [63:56]; unused bytes are 0.
REQ-012 Port: rx_valid  out  1  one-clk pulse when a frame is delivered.
REQ-013 Port: stuff_err, crc_err, form_err  out  1 each  one-clk error pulses.
REQ-014 Port: busy  out  1  high in every state except IDLE.

Function
REQ-015 CAN_RX SHALL pass through a 2-FF synchronizer; every bit decision SHALL use the synchronized value, and only in cycles where baud_clk=1.
REQ-016 The FSM SHALL have the states IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF and ERR.
REQ-017 IDLE: a dominant sample SHALL be taken as SOF and SHALL move the FSM to ARB; a recessive sample keeps IDLE.
REQ-018 De-stuffing SHALL run from SOF through the last CRC bit:
  - After 5 equal consecutive bits, the next bit is a stuff bit and SHALL be discarded without advancing the field counter.
  - A stuff bit equal to the preceding bit SHALL pulse stuff_err and enter ERR.
REQ-019 ARB SHALL shift in 11 ID bits MSB-first, then RTR.
REQ-020 CTRL SHALL shift in IDE, r0 and DLC[3:0].
  - IDE=1 SHALL pulse form_err and enter ERR (extended frames are unsupported).
REQ-021 Data byte count:
  - 0 when RTR=1.
  - Otherwise min(DLC,8).
  - A count of 0 SHALL skip DATA and go to CRC.
REQ-022 CRC-15, polynomial 0x4599, initial value 0:
  - SHALL cover the de-stuffed bits from SOF through the last data bit.
  - The received 15-bit CRC SHALL be compared with it at the end of CRC.
REQ-023 Delimiters: a dominant CRC delimiter, ACK delimiter, or any of the 7 EOF bits SHALL pulse form_err and enter ERR.
REQ-024 ack_drive timing:
  - ack_drive SHALL go to 1 in the clk after the CRC-delimiter sample when the CRC matched.
  - ack_drive SHALL return to 0 in the clk after the ACK-slot sample.
  - ack_drive is independent of the filter.
REQ-025 A CRC mismatch SHALL pulse crc_err in the clk after the CRC-delimiter sample and enter ERR; ack_drive stays 0.
REQ-026 The level sampled in ACK_SLOT SHALL be ignored by this block.
REQ-027 Delivery:
  - After the 7th recessive EOF bit, the FSM SHALL return to IDLE.
  - If ID==ADDRESS or ACCEPT_ALL=1, the block SHALL update rx_id, rx_rtr, rx_dlc and rx_data, and pulse rx_valid one clk after that sample.
  - Otherwise it SHALL return to IDLE silently.
REQ-028 The rx_* outputs SHALL hold their values between deliveries; rejected or errored frames SHALL NOT modify them.
REQ-029 ERR SHALL wait for 11 consecutive recessive samples, then enter IDLE; a dominant sample restarts the count.
REQ-030 Error pulses SHALL be mutually exclusive; at most one error pulse per frame.

Reset
REQ-031 While RESET=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and all counters, shift registers, the CRC register and the synchronizer SHALL be cleared.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no rx_valid and no error pulse; after release, reception resumes at the next SOF.

Structure
REQ-033 A shared package (can_pkg) SHALL hold:
  - the FSM state encoding;
  - the field widths (ID=11, DLC=4, CRC=15);
  - CRC_POLY=15'h4599;
  - STUFF_LIMIT=5, EOF_LEN=7, IDLE_LEN=11.
  The TX path SHALL use the same package.
REQ-034 The CRC SHALL be a sub-module, can_crc15 (inputs: clk, RESET, clear, enable, bit_in; output: crc[14:0]), shared with the transmitter.

Verification
REQ-035 Good frame: ID 0x025, RTR=0, DLC=4, data A5 5A 0F F0 with correct stuffing and CRC -> ack_drive high for exactly the ACK-slot bit, one rx_valid, rx_data=64'hA55A0FF0_00000000, rx_dlc=4.
REQ-036 Same frame with ID 0x026 and ACCEPT_ALL=0 -> ack_drive asserted, no rx_valid, rx_* unchanged.
REQ-037 Good frame with one CRC bit flipped -> crc_err pulse, ack_drive stays 0, no rx_valid, return to IDLE after 11 recessive bits.
REQ-038 Six consecutive dominant bits inside the ID -> stuff_err pulse at the 6th bit, then ERR.
REQ-039 RTR frame, ID 0x025, DLC=8 -> rx_valid, rx_rtr=1, rx_data=0, no DATA state visited.
REQ-040 RESET pulled low during DATA byte 2 -> all outputs 0; a following good frame is received correctly.
